// File: rtl/gpio_event_logger.sv
// gpio_event_logger
//   Watches a WIDTH-bit GPIO bus and records every change as a {timestamp, value}
//   word in a DEPTH-entry first-word-fall-through FIFO. The consumer drains
//   entries through a valid/ready handshake.
//
//   Build option: define GPIO_LOGGER_TIMESTAMP_EN to build the free-running
//   timestamp counter and store it with each entry. Without it there is no
//   counter, each entry holds only the GPIO value, and the timestamp field of
//   o_Data reads 0.
//
// Ports
//   i_Clk             rising-edge clock
//   i_Reset           synchronous active-high reset; discards stored entries
//   i_Enable          1 = log changes, 0 = follow the bus without logging
//   i_Gpio            monitored bus, already synchronous to i_Clk
//   o_Valid           FIFO head is valid
//   i_Ready           consumer takes the head when o_Valid && i_Ready
//   o_Data            head entry {timestamp, gpio value}
//   o_Count           number of stored entries, 0..DEPTH
//   o_Overflow        sticky flag: a change was dropped because the FIFO was full
//   i_Clear_Overflow  clears o_Overflow (a drop on the same edge wins)
module gpio_event_logger #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 16
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Enable,
  input  logic [WIDTH-1:0]            i_Gpio,
  output logic                        o_Valid,
  input  logic                        i_Ready,
  output logic [TS_WIDTH+WIDTH-1:0]   o_Data,
  output logic [$clog2(DEPTH):0]      o_Count,
  output logic                        o_Overflow,
  input  logic                        i_Clear_Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef GPIO_LOGGER_TIMESTAMP_EN
  localparam int EW = TS_WIDTH + WIDTH;
`else
  localparam int EW = WIDTH;
`endif

  logic [WIDTH-1:0] r_Prev;
  logic             r_Armed;
  logic [AW-1:0]    r_Wr;
  logic [AW-1:0]    r_Rd;
  logic [CW-1:0]    r_Count;
  logic [EW-1:0]    r_Data;
  logic             r_Overflow;
  logic [EW-1:0]    r_Mem [DEPTH];

  logic [EW-1:0]    w_Entry;
  logic [AW-1:0]    w_RdNext;
  logic             w_Full;
  logic             w_Push;
  logic             w_Pop;
  logic             w_Write;
  logic             w_Drop;

`ifdef GPIO_LOGGER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_Ts;

  // Free-running timestamp; the value captured with an event is the count
  // held before the edge that detects the change.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_Ts <= '0;
    else         r_Ts <= r_Ts + 1'b1;
  end

  assign w_Entry = {r_Ts, i_Gpio};
  assign o_Data  = r_Data;
`else
  assign w_Entry = i_Gpio;
  assign o_Data  = {{TS_WIDTH{1'b0}}, r_Data};
`endif

  // A push while full only lands if the head leaves on the same edge, which
  // frees exactly the slot the write pointer is sitting on.
  assign w_Full   = (r_Count == CW'(DEPTH));
  assign w_Push   = r_Armed && i_Enable && (i_Gpio != r_Prev);
  assign w_Pop    = o_Valid && i_Ready;
  assign w_Write  = w_Push && (!w_Full || w_Pop);
  assign w_Drop   = w_Push && w_Full && !w_Pop;
  assign w_RdNext = r_Rd + 1'b1;

  assign o_Valid    = (r_Count != '0);
  assign o_Count    = r_Count;
  assign o_Overflow = r_Overflow;

  // Storage array carries no reset; clearing the pointers is what empties it.
  always_ff @(posedge i_Clk) begin
    if (w_Write) r_Mem[r_Wr] <= w_Entry;
  end

  // Control path. r_Data is a registered copy of the head so a fresh entry
  // written into an empty FIFO (or into a FIFO whose last entry is leaving)
  // appears on o_Data right after the detecting edge. r_Prev follows the bus
  // on every armed edge, even while disabled, so re-enabling never fires a
  // stale event.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Prev     <= '0;
      r_Armed    <= 1'b0;
      r_Wr       <= '0;
      r_Rd       <= '0;
      r_Count    <= '0;
      r_Data     <= '0;
      r_Overflow <= 1'b0;
    end else begin
      r_Prev  <= i_Gpio;
      r_Armed <= 1'b1;

      if (w_Write) r_Wr <= r_Wr + 1'b1;
      if (w_Pop)   r_Rd <= w_RdNext;

      case ({w_Write, w_Pop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase

      if (w_Pop) begin
        if (r_Count > CW'(1)) r_Data <= r_Mem[w_RdNext];
        else if (w_Write)     r_Data <= w_Entry;
      end else if (!o_Valid && w_Write) begin
        r_Data <= w_Entry;
      end

      if (w_Drop)                r_Overflow <= 1'b1;
      else if (i_Clear_Overflow) r_Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_event_logger.sv
// tb_gpio_event_logger
//   Directed bench for gpio_event_logger with WIDTH=4, DEPTH=4, TS_WIDTH=16.
//   Expected timestamps come from the bench's own cycle count since reset;
//   when GPIO_LOGGER_TIMESTAMP_EN is not defined the timestamp field is 0.
module tb_gpio_event_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  gpio;
  logic        ready;
  logic        clr;
  logic        valid;
  logic [19:0] data;
  logic [2:0]  count;
  logic        ovf;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] tsNow = '0;

  gpio_event_logger #(.WIDTH(4), .DEPTH(4), .TS_WIDTH(16)) dut (
    .i_Clk            (clk),
    .i_Reset          (reset),
    .i_Enable         (enable),
    .i_Gpio           (gpio),
    .o_Valid          (valid),
    .i_Ready          (ready),
    .o_Data           (data),
    .o_Count          (count),
    .o_Overflow       (ovf),
    .i_Clear_Overflow (clr)
  );

  always #5 clk = ~clk;

  // Expected entry word for a change captured at timestamp ts.
  function automatic logic [19:0] expData(input logic [15:0] ts, input logic [3:0] v);
`ifdef GPIO_LOGGER_TIMESTAMP_EN
    return {ts, v};
`else
    return {16'd0, v};
`endif
  endfunction

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  // tsNow mirrors the counter value present after that edge.
  task automatic applyStimulus(input logic r, input logic en, input logic [3:0] g,
                               input logic rdy, input logic c);
    reset  = r;
    enable = en;
    gpio   = g;
    ready  = rdy;
    clr    = c;
    @(posedge clk);
    if (r) tsNow = '0;
    else   tsNow = tsNow + 16'd1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  vals [5];
    logic [15:0] tsExp [5];
    logic [19:0] q4 [4];
    logic [15:0] t;

    // Scenario 1: reset, arming with a steady bus logs nothing.
    applyStimulus(1, 1, 4'b0101, 0, 0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ovf",   32'(ovf),   32'd0);
    checkOutput("rst_data",  32'(data),  32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 4'b0101, 0, 0);
      checkOutput("arm_valid", 32'(valid), 32'd0);
      checkOutput("arm_count", 32'(count), 32'd0);
    end

    // Scenario 2: change at the edge where the counter holds 7.
    applyStimulus(1, 1, 4'b0101, 0, 0);
    applyStimulus(0, 1, 4'b0101, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 4'b0101, 0, 0);
    applyStimulus(0, 1, 4'b0110, 0, 0);
    checkOutput("s2_valid", 32'(valid), 32'd1);
    checkOutput("s2_data",  32'(data),  32'(expData(16'd7, 4'b0110)));
    checkOutput("s2_count", 32'(count), 32'd1);
    applyStimulus(0, 1, 4'b0110, 1, 0);
    checkOutput("s2_pop_valid", 32'(valid), 32'd0);
    checkOutput("s2_pop_count", 32'(count), 32'd0);

    // Scenario 3: five changes into a 4-deep FIFO; the fifth is dropped.
    vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0011;
    vals[3] = 4'b0100; vals[4] = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      tsExp[i] = tsNow;
      applyStimulus(0, 1, vals[i], 0, 0);
    end
    checkOutput("s3_count", 32'(count), 32'd4);
    checkOutput("s3_ovf",   32'(ovf),   32'd1);
    // Clear and drop on the same edge: set wins.
    applyStimulus(0, 1, 4'b1000, 0, 1);
    checkOutput("s3_setwins_ovf",   32'(ovf),   32'd1);
    checkOutput("s3_setwins_count", 32'(count), 32'd4);
    applyStimulus(0, 1, 4'b1000, 0, 1);
    checkOutput("s3_clear_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("s3_drain_valid", 32'(valid), 32'd1);
      checkOutput("s3_drain_data",  32'(data),  32'(expData(tsExp[i], vals[i])));
      applyStimulus(0, 1, 4'b1000, 1, 0);
    end
    checkOutput("s3_empty_valid", 32'(valid), 32'd0);
    checkOutput("s3_empty_count", 32'(count), 32'd0);

    // Scenario 4: full FIFO with push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      tsExp[i] = tsNow;
      applyStimulus(0, 1, vals[i], 0, 0);
    end
    checkOutput("s4_full_count", 32'(count), 32'd4);
    q4[0] = expData(tsExp[1], vals[1]);
    q4[1] = expData(tsExp[2], vals[2]);
    q4[2] = expData(tsExp[3], vals[3]);
    q4[3] = expData(tsNow, 4'b0101);
    applyStimulus(0, 1, 4'b0101, 1, 0);
    checkOutput("s4_pp_count", 32'(count), 32'd4);
    checkOutput("s4_pp_ovf",   32'(ovf),   32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("s4_drain_data", 32'(data), 32'(q4[i]));
      applyStimulus(0, 1, 4'b0101, 1, 0);
    end
    checkOutput("s4_empty_count", 32'(count), 32'd0);

    // Scenario 5: toggles while disabled are tracked but never logged.
    applyStimulus(0, 0, 4'b1010, 0, 0);
    checkOutput("s5_dis_count", 32'(count), 32'd0);
    applyStimulus(0, 0, 4'b0101, 0, 0);
    checkOutput("s5_dis_count", 32'(count), 32'd0);
    applyStimulus(0, 0, 4'b1010, 0, 0);
    checkOutput("s5_dis_count", 32'(count), 32'd0);
    applyStimulus(0, 1, 4'b1010, 0, 0);
    checkOutput("s5_en_count", 32'(count), 32'd0);
    checkOutput("s5_en_valid", 32'(valid), 32'd0);
    t = tsNow;
    applyStimulus(0, 1, 4'b0011, 0, 0);
    checkOutput("s5_log_count", 32'(count), 32'd1);
    checkOutput("s5_log_data",  32'(data),  32'(expData(t, 4'b0011)));
    applyStimulus(0, 1, 4'b0011, 1, 0);
    checkOutput("s5_pop_count", 32'(count), 32'd0);

    // Scenario 6: reset mid-operation discards entries and restarts time.
    applyStimulus(0, 1, 4'b1100, 0, 0);
    applyStimulus(0, 1, 4'b1101, 0, 0);
    checkOutput("s6_count2", 32'(count), 32'd2);
    applyStimulus(1, 1, 4'b1101, 0, 0);
    checkOutput("s6_rst_valid", 32'(valid), 32'd0);
    checkOutput("s6_rst_count", 32'(count), 32'd0);
    checkOutput("s6_rst_ovf",   32'(ovf),   32'd0);
    checkOutput("s6_rst_data",  32'(data),  32'd0);
    applyStimulus(0, 1, 4'b1101, 0, 0);
    checkOutput("s6_arm_count", 32'(count), 32'd0);
    applyStimulus(0, 1, 4'b0110, 0, 0);
    checkOutput("s6_ts_count", 32'(count), 32'd1);
    checkOutput("s6_ts_data",  32'(data),  32'(expData(16'd1, 4'b0110)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
